// File: rtl/irq_latch8_pkg.sv
// irq_latch8_pkg
//   Shared constants and helpers for the irq_latch8 request stage that
//   feeds the hc148 8-to-3 priority encoder.
//   NUM_IRQ  : number of interrupt lines
//   CODE_W   : width of the encoder's active-low output code
//   MASK_RST : mask value after reset (everything masked)
//   code_to_idx : converts the encoder's active-low code into a line index
package irq_latch8_pkg;

  localparam int NUM_IRQ = 8;
  localparam int CODE_W  = 3;

  localparam logic [NUM_IRQ-1:0] MASK_RST = 8'hFF;

  // hc148 drives the inverted index of the winning line on out_N.
  function automatic logic [CODE_W-1:0] code_to_idx(input logic [CODE_W-1:0] code_N);
    return ~code_N;
  endfunction

endpackage

// File: rtl/sync_fall.sv
// sync_fall
//   Synchronizes one asynchronous active-low request line and flags its
//   falling edge for exactly one cycle.
//   Parameters : SYNC_STAGES - synchronizer depth (2 or 3)
//   Ports      : clk   - clock
//                rst_N - synchronous active-low reset
//                d_N   - raw asynchronous active-low request
//                fall  - one-cycle pulse on a synchronized 1->0 transition
module sync_fall #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_N,
  input  logic d_N,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // All flops reset to the idle (high) level so that a line that is idle
  // when reset is released can never look like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_N) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_N};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign fall = prev & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/irq_latch8.sv
// irq_latch8
//   Request stage in front of an hc148 priority encoder. Captures falling
//   edges of eight active-low interrupt lines into a pending register,
//   hides masked lines from the encoder, clears the serviced line on
//   acknowledge and blanks the encoder for HOLD cycles afterwards.
//   Parameters : SYNC_STAGES - synchronizer depth per line (2 or 3)
//                HOLD        - EI_N blanking cycles after an ack (0 = none)
//   Ports      : clk        - clock
//                rst_N      - synchronous active-low reset
//                irq_N      - raw active-low requests, bit 7 highest priority
//                en         - global enable
//                mask_we    - mask write strobe
//                mask_d     - new mask value, 1 = masked
//                ack        - one-cycle acknowledge pulse
//                ack_code_N - hc148 out_N code of the line being acknowledged
//                in_N       - to hc148 in_N, ~(pend & ~mask)
//                EI_N       - to hc148 EI_N, registered
//                pend       - pending register status
module irq_latch8
  import irq_latch8_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD        = 2
) (
  input  logic               clk,
  input  logic               rst_N,
  input  logic [NUM_IRQ-1:0] irq_N,
  input  logic               en,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_d,
  input  logic               ack,
  input  logic [CODE_W-1:0]  ack_code_N,
  output logic [NUM_IRQ-1:0] in_N,
  output logic               EI_N,
  output logic [NUM_IRQ-1:0] pend
);

  localparam int HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD);

  logic [NUM_IRQ-1:0] fall;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] mask;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_nxt;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    sync_fall #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_fall (
      .clk  (clk),
      .rst_N(rst_N),
      .d_N  (irq_N[i]),
      .fall (fall[i])
    );
  end

  // An acknowledge targets exactly one line, decoded from the encoder code.
  always_comb begin
    clr = '0;
    if (ack) begin
      clr[code_to_idx(ack_code_N)] = 1'b1;
    end
  end

  // An ack reloads the counter even if a hold is already running.
  always_comb begin
    hold_nxt = hold_cnt;
    if (ack) begin
      hold_nxt = HOLD_LD;
    end else if (hold_cnt != '0) begin
      hold_nxt = hold_cnt - HOLD_W'(1);
    end
  end

  // EI_N is computed from the next counter value so that the encoder is
  // blanked starting on the very edge that samples the ack, and released
  // on the edge where the counter reaches zero.
  // Set is ORed after the clear term, so a new edge wins over an ack.
  always_ff @(posedge clk) begin
    if (!rst_N) begin
      pend     <= '0;
      mask     <= MASK_RST;
      hold_cnt <= '0;
      EI_N     <= 1'b1;
    end else begin
      pend     <= fall | (pend & ~clr);
      if (mask_we) begin
        mask <= mask_d;
      end
      hold_cnt <= hold_nxt;
      EI_N     <= ~en | (hold_nxt != '0);
    end
  end

  assign in_N = ~(pend & ~mask);

endmodule

// File: tb/tb_irq_latch8.sv
// tb_irq_latch8
//   Directed-vector bench for irq_latch8 with the default parameters.
//   The stimulus process drives inputs one clock at a time and queues the
//   hand-computed response expected after that edge; a monitor process
//   pops the queue on the falling clock edge and compares.
module tb_irq_latch8;

  logic       clk;
  logic       rst_N;
  logic [7:0] irq_N;
  logic       en;
  logic       mask_we;
  logic [7:0] mask_d;
  logic       ack;
  logic [2:0] ack_code_N;
  logic [7:0] in_N;
  logic       EI_N;
  logic [7:0] pend;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] pend;
    logic [7:0] in_n;
    logic       ei_n;
    bit         deep;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  irq_latch8 #(
    .SYNC_STAGES(2),
    .HOLD       (2)
  ) dut (
    .clk       (clk),
    .rst_N     (rst_N),
    .irq_N     (irq_N),
    .en        (en),
    .mask_we   (mask_we),
    .mask_d    (mask_d),
    .ack       (ack),
    .ack_code_N(ack_code_N),
    .in_N      (in_N),
    .EI_N      (EI_N),
    .pend      (pend)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts rising edges so queued expectations know which cycle they belong to.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic r, input logic [7:0] irq, input logic e,
                               input logic mw, input logic [7:0] md,
                               input logic a, input logic [2:0] code);
    rst_N      = r;
    irq_N      = irq;
    en         = e;
    mask_we    = mw;
    mask_d     = md;
    ack        = a;
    ack_code_N = code;
    @(posedge clk);
    #1;
  endtask

  // Queue the response expected after the edge just taken.
  task automatic checkOutput(input string nm, input logic [7:0] p, input logic [7:0] i,
                             input logic ei, input bit deep = 1'b0);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.pend = p;
    e.in_n = i;
    e.ei_n = ei;
    e.deep = deep;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.cyc != cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s: sampled in cycle %0d, expected cycle %0d", cur.name, cyc, cur.cyc);
      end else begin
        cmp({cur.name, ".pend"}, pend, cur.pend);
        cmp({cur.name, ".in_N"}, in_N, cur.in_n);
        cmp({cur.name, ".EI_N"}, {7'd0, EI_N}, {7'd0, cur.ei_n});
        if (cur.deep) begin
          cmp({cur.name, ".mask"}, dut.mask, 8'hFF);
          cmp({cur.name, ".hold_cnt"}, 8'(dut.hold_cnt), 8'h00);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_N      = 1'b0;
    irq_N      = 8'h00;
    en         = 1'b0;
    mask_we    = 1'b0;
    mask_d     = 8'h00;
    ack        = 1'b0;
    ack_code_N = 3'b111;

    // Reset held with all lines low.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'b111);
      checkOutput("reset", 8'h00, 8'hFF, 1'b1);
    end

    // Release with idle lines: nothing may become pending.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 3'b111);
      checkOutput("post_reset", 8'h00, 8'hFF, 1'b1);
    end

    // Unmask everything and enable.
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 3'b111);
    checkOutput("mask_clear", 8'h00, 8'hFF, 1'b0);

    // Single request on line 5: pending exactly two edges after the fall.
    applyStimulus(1'b1, 8'hDF, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l5_k0", 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hDF, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l5_k1", 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hDF, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l5_k2", 8'h20, 8'hDF, 1'b0);
    applyStimulus(1'b1, 8'hDF, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l5_held", 8'h20, 8'hDF, 1'b0);

    // Add line 1.
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l1_k0", 8'h20, 8'hDF, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l1_k1", 8'h20, 8'hDF, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l1_k2", 8'h22, 8'hDD, 1'b0);

    // Acknowledge line 5 (code 010): clear and hold for two cycles.
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b1, 3'b010);
    checkOutput("ack5", 8'h02, 8'hFD, 1'b1);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("ack5_h1", 8'h02, 8'hFD, 1'b1);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("ack5_h2", 8'h02, 8'hFD, 1'b0);

    // Release line 5, then fall again with the ack landing on the set cycle.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'hFD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
      checkOutput("l5_rise", 8'h02, 8'hFD, 1'b0);
    end
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("sc_k0", 8'h02, 8'hFD, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("sc_k1", 8'h02, 8'hFD, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b1, 3'b010);
    checkOutput("set_wins", 8'h22, 8'hDD, 1'b1);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("set_wins_h1", 8'h22, 8'hDD, 1'b1);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("set_wins_h2", 8'h22, 8'hDD, 1'b0);

    // Ack of a non-pending line only starts a hold; acks during a hold reload it.
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b1, 3'b111);
    checkOutput("ack_nonpend", 8'h22, 8'hDD, 1'b1);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("nonpend_h1", 8'h22, 8'hDD, 1'b1);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b1, 3'b010);
    checkOutput("reload_ack5", 8'h02, 8'hFD, 1'b1);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b1, 3'b110);
    checkOutput("reload_ack1", 8'h00, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("reload_h1", 8'h00, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("reload_h2", 8'h00, 8'hFF, 1'b0);

    // Mask line 7, request it, then unmask.
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b1, 8'h80, 1'b0, 3'b111);
    checkOutput("mask80", 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h5D, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l7_k0", 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h5D, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l7_k1", 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h5D, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l7_masked", 8'h80, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h5D, 1'b1, 1'b1, 8'h00, 1'b0, 3'b111);
    checkOutput("l7_unmask", 8'h80, 8'h7F, 1'b0);

    // Clear line 7, raise lines 2 and 3, then reset in the middle of a hold.
    applyStimulus(1'b1, 8'h5D, 1'b1, 1'b0, 8'h00, 1'b1, 3'b000);
    checkOutput("ack7", 8'h00, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'h51, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l23_k0", 8'h00, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'h51, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l23_k1", 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h51, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l23_k2", 8'h0C, 8'hF3, 1'b0);
    applyStimulus(1'b1, 8'h51, 1'b1, 1'b0, 8'h00, 1'b1, 3'b111);
    checkOutput("hold_start", 8'h0C, 8'hF3, 1'b1);
    applyStimulus(1'b0, 8'h51, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("reset_mid_hold", 8'h00, 8'hFF, 1'b1, 1'b1);

    // After release the mask is all ones again; enable still tracks en.
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("rel2", 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l0_k0", 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l0_k1", 8'h00, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("l0_masked", 8'h01, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("en_off", 8'h01, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0, 3'b111);
    checkOutput("en_on", 8'h01, 8'hFF, 1'b0);

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
